dth: RTL and testbench

- Frame-delimiter decoder: the receive-side counterpart of the flag-bit frame encoder.
- Accepts (DATA_WIDTH+1)-bit beats whose MSB flag marks the frame head and frame tail, with flag=0 on body beats.
- Strips the flag and re-creates explicit framing for downstream logic:
  - write strobe
  - start-of-frame and end-of-frame pulses
  - frame length
  - error pulse
- Sits directly after the encoded link, in front of the packet buffer.

---
 rtl/dth_if.sv | 28 ++
 rtl/dth.sv | 117 +++++++++++
 tb/tb_dth.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dth_if.sv
// Link-side bundle for the frame-delimiter decoder: flagged beats in, framed beats out.
// Ports: iv_data/i_data_wr (encoded beat in); ov_data/o_data_wr/o_sop/o_eop/ov_len/o_err (framed out).
// Pure wiring, no storage; no backpressure path exists on either side.
interface dth_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 7
);
  logic [DATA_WIDTH:0]   iv_data;    // [DATA_WIDTH] = head/tail flag
  logic                  i_data_wr;
  logic [DATA_WIDTH-1:0] ov_data;
  logic                  o_data_wr;
  logic                  o_sop;
  logic                  o_eop;
  logic [LEN_WIDTH-1:0]  ov_len;
  logic                  o_err;

  // Source of encoded beats / sink of decoded frames.
  modport master (
    output iv_data, i_data_wr,
    input  ov_data, o_data_wr, o_sop, o_eop, ov_len, o_err
  );

  // The decoder itself.
  modport slave (
    input  iv_data, i_data_wr,
    output ov_data, o_data_wr, o_sop, o_eop, ov_len, o_err
  );
endinterface

// File: rtl/dth.sv
// Frame-delimiter decoder: strips the MSB head/tail flag and regenerates sop/eop/len/err framing.
// Latency: 1 cycle, every output registered. Ports: i_clk, i_rst (async high), bus (dth_if.slave).
// No backpressure: a beat is taken every cycle i_data_wr=1; gaps hold state and clear the pulses.
module dth #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 64,
  parameter int LEN_WIDTH  = 7
) (
  input  logic  i_clk,
  input  logic  i_rst,
  dth_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN_C = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE_C     = LEN_WIDTH'(1);

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  cnt_q;      // beats of the current frame already emitted
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wr_q;
  logic                  sop_q;
  logic                  eop_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  err_q;

  logic                  flag;
  logic [DATA_WIDTH-1:0] payload;
  logic [LEN_WIDTH-1:0]  cnt_inc;    // position of the incoming beat inside the frame

  assign flag    = bus.iv_data[DATA_WIDTH];
  assign payload = bus.iv_data[DATA_WIDTH-1:0];
  assign cnt_inc = cnt_q + ONE_C;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // Pulses default low; data/len hold their last value through gaps.
      wr_q  <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      err_q <= 1'b0;
      if (bus.i_data_wr) begin
        case (state_q)
          IDLE: begin
            if (flag) begin
              wr_q    <= 1'b1;
              sop_q   <= 1'b1;
              data_q  <= payload;
              cnt_q   <= ONE_C;
              state_q <= BODY;
            end else begin
              // Body beat with no head: report once, then swallow up to the lost tail.
              err_q   <= 1'b1;
              state_q <= DROP;
            end
          end
          BODY: begin
            if (flag) begin
              wr_q    <= 1'b1;
              eop_q   <= 1'b1;
              data_q  <= payload;
              len_q   <= cnt_inc;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else if (cnt_inc == MAX_LEN_C) begin
              // Overlong frame: close it on this beat so downstream never sees an
              // unterminated frame, and flag it; the rest up to the tail is discarded.
              wr_q    <= 1'b1;
              eop_q   <= 1'b1;
              err_q   <= 1'b1;
              data_q  <= payload;
              len_q   <= MAX_LEN_C;
              cnt_q   <= '0;
              state_q <= DROP;
            end else begin
              wr_q   <= 1'b1;
              data_q <= payload;
              cnt_q  <= cnt_inc;
            end
          end
          DROP: begin
            // A flagged beat here is the tail of the abandoned frame.
            if (flag) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.ov_data   = data_q;
  assign bus.o_data_wr = wr_q;
  assign bus.o_sop     = sop_q;
  assign bus.o_eop     = eop_q;
  assign bus.ov_len    = len_q;
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_dth.sv
module tb_dth;
  localparam int DW      = 8;
  localparam int MAX_LEN = 64;
  localparam int LW      = 7;

  logic i_clk;
  logic i_rst;

  dth_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  dth #(.DATA_WIDTH(DW), .MAX_LEN(MAX_LEN), .LEN_WIDTH(LW)) u_dth (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One observable output event; data only meaningful with wr, len only with eop.
  typedef struct packed {
    logic          wr;
    logic          sop;
    logic          eop;
    logic          err;
    logic [DW-1:0] data;
    logic [LW-1:0] len;
    logic [31:0]   cyc;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic [31:0] cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Collect every cycle where any pulse is present.
  always @(negedge i_clk) begin
    ev_t e;
    if (!i_rst && (bus.o_data_wr || bus.o_sop || bus.o_eop || bus.o_err)) begin
      e.wr   = bus.o_data_wr;
      e.sop  = bus.o_sop;
      e.eop  = bus.o_eop;
      e.err  = bus.o_err;
      e.data = bus.o_data_wr ? bus.ov_data : '0;
      e.len  = bus.o_eop ? bus.ov_len : '0;
      e.cyc  = cyc;
      act_q.push_back(e);
    end
  end

  // Reference model: where are we in the stream of frames.
  bit m_in_frame = 0;  // head seen, tail not yet
  bit m_dropping = 0;  // discarding until next flagged beat
  int m_len      = 0;  // beats of current frame seen so far

  function automatic ev_t mk(bit wr, bit sop, bit eop, bit err, logic [DW-1:0] d, int len);
    ev_t e;
    e.wr   = wr;
    e.sop  = sop;
    e.eop  = eop;
    e.err  = err;
    e.data = wr ? d : '0;
    e.len  = eop ? LW'(len) : '0;
    e.cyc  = cyc + 1;
    return e;
  endfunction

  function automatic void model_beat(bit flag, logic [DW-1:0] d);
    if (m_dropping) begin
      if (flag) m_dropping = 0;
    end else if (!m_in_frame) begin
      if (flag) begin
        m_in_frame = 1;
        m_len = 1;
        exp_q.push_back(mk(1, 1, 0, 0, d, 0));
      end else begin
        m_dropping = 1;
        exp_q.push_back(mk(0, 0, 0, 1, d, 0));
      end
    end else if (flag) begin
      m_in_frame = 0;
      exp_q.push_back(mk(1, 0, 1, 0, d, m_len + 1));
    end else if (m_len + 1 < MAX_LEN) begin
      m_len++;
      exp_q.push_back(mk(1, 0, 0, 0, d, 0));
    end else begin
      m_in_frame = 0;
      m_dropping = 1;
      exp_q.push_back(mk(1, 0, 1, 1, d, MAX_LEN));
    end
  endfunction

  task automatic drive_beat(input bit flag, input logic [DW-1:0] d);
    bus.iv_data   = {flag, d};
    bus.i_data_wr = 1'b1;
    model_beat(flag, d);
    @(posedge i_clk);
    #1;
    bus.i_data_wr = 1'b0;
  endtask

  task automatic drive_gap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_data_wr = 1'b0;
      bus.iv_data   = (DW + 1)'($urandom);  // must be ignored
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    bus.i_data_wr = 1'b0;
    bus.iv_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++;
    if ({bus.o_data_wr, bus.o_sop, bus.o_eop, bus.o_err, bus.ov_data, bus.ov_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr=%b sop=%b eop=%b err=%b data=%h len=%0d, want all 0",
               bus.o_data_wr, bus.o_sop, bus.o_eop, bus.o_err, bus.ov_data, bus.ov_len);
    end
    i_rst = 1'b0;
    drive_gap(3);
    n_checks++;
    if ({bus.o_data_wr, bus.o_sop, bus.o_eop, bus.o_err, bus.ov_data, bus.ov_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got wr=%b sop=%b eop=%b err=%b data=%h len=%0d, want all 0",
               bus.o_data_wr, bus.o_sop, bus.o_eop, bus.o_err, bus.ov_data, bus.ov_len);
    end
    n_checks++;
    if (act_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_events: got %0d events, want 0", act_q.size());
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_basic;
    drive_beat(1, 8'hA5);
    drive_beat(0, 8'h3C);
    drive_beat(0, 8'h7E);
    drive_beat(1, 8'h55);
    drive_gap(3);
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count: got %0d events, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_ev%0d: got %p want %p", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_gap;
    drive_beat(1, 8'hA5);
    drive_beat(0, 8'h3C);
    drive_gap(2);
    drive_beat(0, 8'h7E);
    drive_beat(1, 8'h55);
    drive_gap(3);
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL gap_count: got %0d events, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gap_ev%0d: got %p want %p", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_orphan;
    drive_beat(0, 8'h11);
    drive_beat(0, 8'h22);
    drive_beat(1, 8'h33);
    drive_beat(1, 8'h44);
    drive_beat(1, 8'h55);
    drive_gap(3);
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL orphan_count: got %0d events, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL orphan_ev%0d: got %p want %p", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow;
    drive_beat(1, 8'h01);
    for (int i = 0; i < 70; i++) drive_beat(0, DW'(i + 2));
    drive_beat(1, 8'hFF);
    drive_beat(1, 8'hAA);
    drive_beat(1, 8'hBB);
    drive_gap(3);
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d events, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL overflow_ev%0d: got %p want %p", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midframe;
    drive_beat(1, 8'h5A);
    drive_beat(0, 8'h3C);
    drive_gap(1);
    i_rst = 1'b1;
    m_in_frame = 0;
    m_dropping = 0;
    m_len      = 0;
    #1;
    n_checks++;
    if ({bus.o_data_wr, bus.o_sop, bus.o_eop, bus.o_err, bus.ov_data, bus.ov_len} !== '0) begin
      n_fail++;
      $display("FAIL midrst_zero: got wr=%b eop=%b err=%b data=%h len=%0d, want all 0",
               bus.o_data_wr, bus.o_eop, bus.o_err, bus.ov_data, bus.ov_len);
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    drive_beat(0, 8'h77);
    drive_beat(0, 8'h88);
    drive_beat(1, 8'h99);
    drive_beat(1, 8'hC1);
    drive_beat(0, 8'hC2);
    drive_beat(1, 8'hC3);
    drive_gap(3);
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d events, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_ev%0d: got %p want %p", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    drive_beat(1, 8'h10);
    drive_beat(0, 8'h11);
    drive_beat(1, 8'h12);
    drive_beat(1, 8'h20);
    drive_beat(1, 8'h21);
    drive_beat(1, 8'h30);
    drive_beat(0, 8'h31);
    drive_beat(0, 8'h32);
    drive_beat(1, 8'h33);
    drive_gap(3);
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d events, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_ev%0d: got %p want %p", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random;
    int len;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 9))
        0: len = $urandom_range(60, 72);              // around/over the limit
        1: len = 0;                                   // orphan burst
        default: len = $urandom_range(2, 12);
      endcase
      if (len == 0) begin
        for (int b = 0; b < int'($urandom_range(1, 3)); b++) drive_beat(0, DW'($urandom));
        drive_beat(1, DW'($urandom));
      end else begin
        for (int b = 0; b < len; b++) begin
          drive_beat((b == 0) || (b == len - 1), DW'($urandom));
          if ($urandom_range(0, 3) == 0) drive_gap($urandom_range(1, 3));
        end
      end
      if ($urandom_range(0, 1) == 0) drive_gap($urandom_range(1, 2));
    end
    drive_gap(3);
    n_checks++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d events, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_ev%0d: got %p want %p", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_orphan();
    test_overflow();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
